// File: rtl/gain_seq_pkg.sv
// Shared opcodes, constants and types for the multi-channel gain sequencer.
package gain_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPC_W  = 3;

  localparam logic [OPC_W-1:0]  OP_FIXSI   = 3'b001;
  localparam logic [OPC_W-1:0]  OP_FLOATIS = 3'b010;
  localparam logic [OPC_W-1:0]  OP_FMULS   = 3'b100;
  localparam logic [DATA_W-1:0] FLOAT_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_t;

  // One FPU operation request: opcode plus both operands
  typedef struct packed {
    logic [OPC_W-1:0]  n;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } fpu_req_t;

  // Per-channel op index to FPU opcode: convert, multiply, convert back
  function automatic logic [OPC_W-1:0] op_code(input logic [1:0] op);
    case (op)
      2'd0:    return OP_FLOATIS;
      2'd1:    return OP_FMULS;
      default: return OP_FIXSI;
    endcase
  endfunction

endpackage

// File: rtl/fpu_op_issuer.sv
// Drives one FPU custom-instruction op: registers operands/opcode, pulses
// start, watches for done while the sequencer waits and flags a watchdog
// timeout when done does not arrive in time.
module fpu_op_issuer
  import gain_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic [OPC_W-1:0]  req_n,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              wait_en,
  input  logic              fpu_done,
  output logic              done_c,
  output logic              timeout_c,
  output logic [DATA_W-1:0] fpu_dataa,
  output logic [DATA_W-1:0] fpu_datab,
  output logic [OPC_W-1:0]  fpu_n,
  output logic              fpu_start
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  // done is only meaningful while waiting; a pulse during the start cycle is dropped
  assign done_c    = wait_en & fpu_done;
  assign timeout_c = wait_en & ~fpu_done & (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Operand/opcode hold registers, start pulse and wait-cycle watchdog
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fpu_start <= 1'b0;
      fpu_n     <= OP_FLOATIS;
      fpu_dataa <= '0;
      fpu_datab <= '0;
      wait_cnt  <= '0;
    end else begin
      fpu_start <= load;
      if (load) begin
        fpu_n     <= req_n;
        fpu_dataa <= req_a;
        fpu_datab <= req_b;
        wait_cnt  <= '0;
      end else if (wait_en && !fpu_done) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gain_seq_mc.sv
// Multi-channel gain sequencer: accepts a frame of NUM_CH int samples with
// float gains, runs FLOATIS -> FMULS -> FIXSI per channel on the shared FPU
// and returns the frame of int results.
// Optional build macro GAIN_SEQ_UNITY_BYPASS_EN: channels whose gain is
// exactly 1.0 pass the sample straight through in one cycle with no FPU ops.
module gain_seq_mc
  import gain_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [32*NUM_CH-1:0]     in_sample,
  input  logic [32*NUM_CH-1:0]     in_gain,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*NUM_CH-1:0]     out_sample,
  output logic [31:0]              fpu_dataa,
  output logic [31:0]              fpu_datab,
  output logic [2:0]               fpu_n,
  output logic                     fpu_start,
  input  logic [31:0]              fpu_result,
  input  logic                     fpu_done,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LAST_CH = NUM_CH - 1;

  typedef logic [NUM_CH-1:0][DATA_W-1:0] frame_t;

  state_t            state, state_d;
  logic [CH_W-1:0]   ch, ch_d;
  logic [1:0]        op, op_d;
  frame_t            smp_q, smp_d;
  frame_t            gain_q, gain_d;
  frame_t            out_q, out_d;
  logic [DATA_W-1:0] temp_q, temp_d;
  logic              err_d;
  logic              enter_c;
  logic              skip_c;
  logic              load_c;
  logic              done_c;
  logic              timeout_c;
  logic              last_ch_c;
  fpu_req_t          req_c;

  assign out_sample = out_q;
  assign last_ch_c  = (ch == CH_W'(LAST_CH));

  // Channel/op sequencing: next state and datapath updates
  always_comb begin
    state_d = state;
    ch_d    = ch;
    op_d    = op;
    smp_d   = smp_q;
    gain_d  = gain_q;
    out_d   = out_q;
    temp_d  = temp_q;
    err_d   = timeout_err;
    enter_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          smp_d   = in_sample;
          gain_d  = in_gain;
          ch_d    = '0;
          op_d    = 2'd0;
          state_d = ST_ISSUE;
          enter_c = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef GAIN_SEQ_UNITY_BYPASS_EN
        if (op == 2'd0 && gain_q[ch] == FLOAT_ONE) begin
          out_d[ch] = smp_q[ch];
          if (last_ch_c) begin
            state_d = ST_OUT;
          end else begin
            ch_d    = ch + CH_W'(1);
            state_d = ST_ISSUE;
            enter_c = 1'b1;
          end
        end
`endif
      end
      ST_WAIT: begin
        if (done_c && op != 2'd2) begin
          temp_d  = fpu_result;
          op_d    = op + 2'd1;
          state_d = ST_ISSUE;
          enter_c = 1'b1;
        end else if (done_c || timeout_c) begin
          // final result, or a watchdog abort that zeroes the channel
          out_d[ch] = done_c ? fpu_result : '0;
          if (timeout_c) err_d = 1'b1;
          if (last_ch_c) begin
            state_d = ST_OUT;
          end else begin
            ch_d    = ch + CH_W'(1);
            op_d    = 2'd0;
            state_d = ST_ISSUE;
            enter_c = 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands for the op being entered, built from next-cycle register values
  always_comb begin
    req_c.n = op_code(op_d);
    req_c.a = '0;
    req_c.b = '0;
    skip_c  = 1'b0;
    unique case (op_d)
      2'd0: req_c.a = smp_d[ch_d];
      2'd1: begin
        req_c.a = temp_d;
        req_c.b = gain_d[ch_d];
      end
      default: req_c.a = temp_d;
    endcase
`ifdef GAIN_SEQ_UNITY_BYPASS_EN
    skip_c = (op_d == 2'd0) && (gain_d[ch_d] == FLOAT_ONE);
`endif
    load_c = enter_c & ~skip_c;
  end

  // State register, frame storage and registered status outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      ch          <= '0;
      op          <= 2'd0;
      smp_q       <= '0;
      gain_q      <= '0;
      out_q       <= '0;
      temp_q      <= '0;
      timeout_err <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      ch          <= ch_d;
      op          <= op_d;
      smp_q       <= smp_d;
      gain_q      <= gain_d;
      out_q       <= out_d;
      temp_q      <= temp_d;
      timeout_err <= err_d;
      in_ready    <= (state_d == ST_IDLE);
      out_valid   <= (state_d == ST_OUT);
      busy        <= (state_d != ST_IDLE);
    end
  end

  fpu_op_issuer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_issuer (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (load_c),
    .req_n     (req_c.n),
    .req_a     (req_c.a),
    .req_b     (req_c.b),
    .wait_en   (state == ST_WAIT),
    .fpu_done  (fpu_done),
    .done_c    (done_c),
    .timeout_c (timeout_c),
    .fpu_dataa (fpu_dataa),
    .fpu_datab (fpu_datab),
    .fpu_n     (fpu_n),
    .fpu_start (fpu_start)
  );

endmodule

// File: tb/tb_gain_seq_mc.sv
// Directed bench for gain_seq_mc with a behavioural FPU responder.
// Honors GAIN_SEQ_UNITY_BYPASS_EN for the expectations that depend on it.
module tb_gain_seq_mc;
  import gain_seq_pkg::*;

  localparam int unsigned NUM_CH = 4;

`ifdef GAIN_SEQ_UNITY_BYPASS_EN
  localparam int EXP_LAT1    = 29;
  localparam int EXP_STARTS1 = 9;
  localparam int EXP_LAT6    = 5;
  localparam int EXP_STARTS6 = 0;
`else
  localparam int EXP_LAT1    = 37;
  localparam int EXP_STARTS1 = 12;
  localparam int EXP_LAT6    = 37;
  localparam int EXP_STARTS6 = 12;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_sample;
  logic [127:0] in_gain;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_sample;
  logic [31:0]  fpu_dataa;
  logic [31:0]  fpu_datab;
  logic [2:0]   fpu_n;
  logic         fpu_start;
  logic [31:0]  fpu_result;
  logic         fpu_done;
  logic         busy;
  logic         timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  gain_seq_mc #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(64)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sample   (in_sample),
    .in_gain     (in_gain),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sample  (out_sample),
    .fpu_dataa   (fpu_dataa),
    .fpu_datab   (fpu_datab),
    .fpu_n       (fpu_n),
    .fpu_start   (fpu_start),
    .fpu_result  (fpu_result),
    .fpu_done    (fpu_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // ---------------- FPU model ----------------
  int          lat_cfg  = 2;
  bit          spur_en  = 1'b0;
  int          drop_idx = -1;
  int          starts   = 0;
  int          remain   = 0;
  logic [31:0] res_q    = '0;
  logic        done_q   = 1'b0;
  logic [2:0]  pend_n   = '0;
  logic [31:0] pend_a   = '0;
  logic [31:0] pend_b   = '0;
  bit          pend_drop = 1'b0;
  logic [2:0]  log_n [0:2];
  logic [31:0] log_a [0:2];
  logic [31:0] log_b [0:2];

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [2:0] n, input logic [31:0] a,
                                           input logic [31:0] b);
    int ai;
    ai = a;
    case (n)
      OP_FLOATIS: return r2f(real'(ai));
      OP_FMULS:   return r2f(f2r(a) * f2r(b));
      OP_FIXSI:   return 32'(int'(f2r(a)));
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

  // done follows start by lat_cfg cycles; optional drop and ISSUE-cycle glitch
  always @(posedge CLK) begin
    done_q <= 1'b0;
    if (fpu_start) begin
      starts    <= starts + 1;
      remain    <= lat_cfg - 1;
      pend_n    <= fpu_n;
      pend_a    <= fpu_dataa;
      pend_b    <= fpu_datab;
      pend_drop <= (starts == drop_idx);
      if (starts < 3) begin
        log_n[starts[1:0]] <= fpu_n;
        log_a[starts[1:0]] <= fpu_dataa;
        log_b[starts[1:0]] <= fpu_datab;
      end
    end else if (remain > 0) begin
      remain <= remain - 1;
      if (remain == 1 && !pend_drop) begin
        done_q <= 1'b1;
        res_q  <= fpu_calc(pend_n, pend_a, pend_b);
      end
    end
  end

  assign fpu_done   = done_q | (spur_en & fpu_start);
  assign fpu_result = (spur_en & fpu_start) ? 32'h7F7F_7F7F : res_q;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] c0, input logic [31:0] c1,
                                         input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Present a frame, return the cycle (acceptance = 0) where out_valid is first seen
  task automatic send_frame(input logic [127:0] s, input logic [127:0] g, output int lat);
    int w;
    w = 0;
    @(negedge CLK);
    in_sample = s;
    in_gain   = g;
    in_valid  = 1'b1;
    while (!in_ready && w < 100) begin
      @(negedge CLK);
      w++;
    end
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    in_valid = 1'b0;
    while (!out_valid && lat < 2000) begin
      @(negedge CLK);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int base;
    int k;

    RESET     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_sample = '0;
    in_gain   = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("rst_fpu_n", 32'(fpu_n), 32'(OP_FLOATIS));
    chk("rst_out_ch0", out_sample[31:0], 32'd0);
    RESET = 1'b0;

    // 1: basic frame, L=2
    base = starts;
    send_frame(pack4(100, -50, 0, 7),
               pack4(32'h4000_0000, 32'h3F00_0000, 32'h4040_0000, 32'h3F80_0000), lat);
    chk("t1_latency", 32'(lat), 32'(EXP_LAT1));
    chk("t1_starts", 32'(starts - base), 32'(EXP_STARTS1));
    chk("t1_out_ch0", out_sample[31:0], 32'd200);
    chk("t1_out_ch1", out_sample[63:32], 32'hFFFF_FFE7);
    chk("t1_out_ch2", out_sample[95:64], 32'd0);
    chk("t1_out_ch3", out_sample[127:96], 32'd7);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_n_op0", 32'(log_n[0]), 32'(OP_FLOATIS));
    chk("t1_n_op1", 32'(log_n[1]), 32'(OP_FMULS));
    chk("t1_n_op2", 32'(log_n[2]), 32'(OP_FIXSI));
    chk("t1_a_op0", log_a[0], 32'd100);
    chk("t1_a_op1", log_a[1], 32'h42C8_0000);
    chk("t1_b_op1", log_b[1], 32'h4000_0000);
    chk("t1_a_op2", log_a[2], 32'h4348_0000);

    // 2: backpressure on the output, new frame offered meanwhile
    in_valid  = 1'b1;
    in_sample = pack4(1, 2, 3, 4);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
      chk("t2_hold_in_ready", 32'(in_ready), 32'd0);
      chk("t2_hold_ch0", out_sample[31:0], 32'd200);
      chk("t2_hold_ch1", out_sample[63:32], 32'hFFFF_FFE7);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    chk("t2_no_new_starts", 32'(starts - base), 32'(EXP_STARTS1));
    release_out();
    chk("t2_valid_fall", 32'(out_valid), 32'd0);
    chk("t2_in_ready", 32'(in_ready), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_idle_hold_ch1", out_sample[63:32], 32'hFFFF_FFE7);

    // 3: ch1 op1 never completes -> watchdog
    base     = starts;
    drop_idx = base + 4;
    send_frame(pack4(10, 20, 30, 40),
               pack4(32'h4000_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4000_0000), lat);
    drop_idx = -1;
    chk("t3_latency", 32'(lat), 32'd96);
    chk("t3_timeout_err", 32'(timeout_err), 32'd1);
    chk("t3_starts", 32'(starts - base), 32'd11);
    chk("t3_out_ch0", out_sample[31:0], 32'd20);
    chk("t3_out_ch1", out_sample[63:32], 32'd0);
    chk("t3_out_ch2", out_sample[95:64], 32'd15);
    chk("t3_out_ch3", out_sample[127:96], 32'd80);
    release_out();

    // 4: reset during ch2 WAIT, stray done afterwards, then a clean frame
    base = starts;
    @(negedge CLK);
    in_sample = pack4(-8, 3, 1000, -1);
    in_gain   = pack4(32'h3F00_0000, 32'h4040_0000, 32'h3F00_0000, 32'h4000_0000);
    in_valid  = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    k = 0;
    while (starts != base + 7 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("t4_reached_ch2", 32'(starts - base), 32'd7);
    chk("t4_busy_before", 32'(busy), 32'd1);
    chk("t4_err_sticky", 32'(timeout_err), 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    chk("t4_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t4_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("t4_rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("t4_rst_fpu_n", 32'(fpu_n), 32'(OP_FLOATIS));
    chk("t4_rst_dataa", fpu_dataa, 32'd0);
    chk("t4_rst_datab", fpu_datab, 32'd0);
    chk("t4_rst_out_ch0", out_sample[31:0], 32'd0);
    chk("t4_stray_done_seen", 32'(fpu_done), 32'd1);
    @(negedge CLK);
    chk("t4_stray_busy", 32'(busy), 32'd0);
    chk("t4_stray_out_valid", 32'(out_valid), 32'd0);
    chk("t4_stray_no_start", 32'(starts - base), 32'd7);
    base = starts;
    send_frame(pack4(-8, 3, 1000, -1),
               pack4(32'h3F00_0000, 32'h4040_0000, 32'h3F00_0000, 32'h4000_0000), lat);
    chk("t4_latency", 32'(lat), 32'd37);
    chk("t4_starts", 32'(starts - base), 32'd12);
    chk("t4_out_ch0", out_sample[31:0], 32'hFFFF_FFFC);
    chk("t4_out_ch1", out_sample[63:32], 32'd9);
    chk("t4_out_ch2", out_sample[95:64], 32'd500);
    chk("t4_out_ch3", out_sample[127:96], 32'hFFFF_FFFE);
    release_out();

    // 5: L=3 with a done glitch in every ISSUE cycle
    lat_cfg = 3;
    spur_en = 1'b1;
    base    = starts;
    send_frame(pack4(5, -6, 8, -100),
               pack4(32'h4040_0000, 32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000), lat);
    spur_en = 1'b0;
    lat_cfg = 2;
    chk("t5_latency", 32'(lat), 32'd49);
    chk("t5_starts", 32'(starts - base), 32'd12);
    chk("t5_out_ch0", out_sample[31:0], 32'd15);
    chk("t5_out_ch1", out_sample[63:32], 32'hFFFF_FFF4);
    chk("t5_out_ch2", out_sample[95:64], 32'd4);
    chk("t5_out_ch3", out_sample[127:96], 32'hFFFF_FFCE);
    release_out();

    // 6: all unity gains
    base = starts;
    send_frame(pack4(123, -456, 0, 65535),
               pack4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000), lat);
    chk("t6_latency", 32'(lat), 32'(EXP_LAT6));
    chk("t6_starts", 32'(starts - base), 32'(EXP_STARTS6));
    chk("t6_out_ch0", out_sample[31:0], 32'd123);
    chk("t6_out_ch1", out_sample[63:32], 32'hFFFF_FE38);
    chk("t6_out_ch2", out_sample[95:64], 32'd0);
    chk("t6_out_ch3", out_sample[127:96], 32'd65535);
    chk("t6_timeout_err", 32'(timeout_err), 32'd0);
    release_out();
    chk("t6_idle", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gain_seq_mc.md
Name: gain_seq_mc

Overview:
- Multi-channel successor to the single-sample gain sequencer.
- Accepts a frame of NUM_CH signed 32-bit integer samples with per-channel IEEE-754 single gains, applies the gain and returns a frame of integer results.
- For each channel in turn, drives the shared floating-point custom-instruction unit through three ops: FLOATIS, then FMULS, then FIXSI.
- Sits between the mic-array sample capture and the DMA/output path. Uses valid/ready on both sides plus a watchdog on the FPU handshake.

Parameters:
- NUM_CH, 4, number of channels per frame (1..16).
- TIMEOUT_CYC, 64, maximum cycles in WAIT before an op is aborted.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame.
- in_sample  in  32*NUM_CH  signed int samples; channel c is at [32c+31:32c].
- in_gain  in  32*NUM_CH  float gains, same packing.
- out_valid  out  1  output frame valid.
- out_ready  in  1  downstream accepts the output frame.
- out_sample  out  32*NUM_CH  signed int results, same packing.
- fpu_dataa  out  32  FPU operand A.
- fpu_datab  out  32  FPU operand B.
- fpu_n  out  3  FPU opcode select.
- fpu_start  out  1  one-cycle op start.
- fpu_result  in  32  FPU result.
- fpu_done  in  1  FPU result valid (single-cycle pulse).
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky; cleared only by RESET.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_sample=0, fpu_dataa/datab=0, fpu_n=OP_FLOATIS, fpu_start=0, busy=0, timeout_err=0. State returns to IDLE.
- RESET mid-frame abandons the frame. No output is produced. A late fpu_done after reset is ignored.
- in_ready = (state==IDLE). in_ready is low while out_valid is high.
- Frame acceptance (in_valid & in_ready): latch all samples and gains, set ch=0, op=0, go to ISSUE.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- ISSUE:
  - fpu_start=1 for exactly one cycle.
  - fpu_n = OP_FLOATIS, OP_FMULS or OP_FIXSI for op = 0, 1, 2.
  - Operands: op0 dataa = sample[ch]; op1 dataa = float temp, datab = gain[ch]; op2 dataa = float product.
  - Go to WAIT and clear the wait counter.
- Operands and fpu_n are registered and held stable from ISSUE through the end of WAIT.
- WAIT:
  - fpu_done is sampled only in WAIT. A done pulse in the ISSUE cycle is ignored.
  - On done with op<2: capture fpu_result into the temp register, op++, go to ISSUE.
  - On done with op==2: write fpu_result into out_sample[ch].
    - If ch<NUM_CH-1: ch++, op=0, go to ISSUE.
    - Otherwise go to OUT.
- Timeout:
  - A counter increments every WAIT cycle without done.
  - If it reaches TIMEOUT_CYC: set timeout_err, force out_sample[ch]=0, skip the remaining ops of that channel and continue with the next channel (or OUT).
- OUT: out_valid=1, held with out_sample stable until out_ready. On handshake: out_valid=0, go to IDLE.
- out_sample holds its last value when idle.
- Latency with an FPU done latency of L≥1 cycles after start:
  - Each op takes L+1 cycles.
  - With acceptance at cycle 0, out_valid rises at cycle 1+3·NUM_CH·(L+1).
- Throughput: one frame per the latency above plus 1 cycle of OUT/IDLE turnaround.
- Arithmetic: the block performs no math itself. Rounding and saturation are defined by the FPU's FIXSI.

Optional Feature:
- Macro: GAIN_SEQ_UNITY_BYPASS_EN.
- When defined: on entry to op0 of a channel, if gain[ch]==32'h3F800000, out_sample[ch]=sample[ch] directly. No FPU ops are issued and the channel costs 1 cycle.
- When not defined: every channel always runs all three ops, giving the fixed latency above.

Decomposition:
- Package gain_seq_pkg holds:
  - opcode constants OP_FIXSI=3'b001, OP_FLOATIS=3'b010, OP_FMULS=3'b100;
  - FLOAT_ONE=32'h3F800000;
  - the state enum typedef.
- Sub-module fpu_op_issuer owns the ISSUE/WAIT handshake, holds operands, and runs the timeout counter. It presents a start/done/timeout interface to the channel/op sequencer in gain_seq_mc.

Test Plan:
- NUM_CH=4, FPU model with L=2; samples {100,-50,0,7}, gains {2.0,0.5,3.0,1.0} → out {200,-25,0,7}; out_valid at cycle 37; exactly 12 start pulses (no bypass).
- out_ready held low 10 cycles after out_valid → out_sample stable, in_ready=0, in_valid ignored; on out_ready: out_valid falls, in_ready=1 next cycle.
- FPU model never asserts done for ch1 op1 → timeout_err=1 after 64 WAIT cycles; out_sample[1]=0; ch2/ch3 computed correctly.
- RESET pulsed during ch2 WAIT → all outputs at reset values next cycle; a stray fpu_done is ignored; a new frame then completes normally.
- fpu_done pulsed in the ISSUE cycle and again at L=3 → only the WAIT-cycle done is captured; latency matches L=3.
- GAIN_SEQ_UNITY_BYPASS_EN defined, all gains 1.0 → out equals in; 0 start pulses; out_valid at cycle 1+NUM_CH.
